boot_image_loader: RTL and testbench
====================================

// Module: boot_image_loader
// PURPOSE
//  Hardware boot sequencer: reads a boot image from a ROM-style read port (active-low CSN, word address A,
//  data Q valid one cycle after the CSN-low edge and held while CSN stays high). Copies the image payload
//  into instruction RAM over a req/gnt write port. Checks the image and raises fetch_enable_o to release the core.
//  Sits between the boot ROM and the instruction-RAM arbiter; it is the reader end of the ROM interface.
// PARAMETERS
//  SRC_AW     10            source word-address width
//  DST_BASE   32'h0000_0000 destination byte address of payload word 0
//  MAGIC      32'hB007_C0DE required value of source word 0
//  MAX_WORDS  512           largest accepted payload length N
// PORTS
//  CLK             in   1       clock
//  RST             in   1       synchronous reset, active high
//  start_i         in   1       one-cycle pulse; begins a load
//  src_csn_o       out  1       source read strobe, active low
//  src_a_o         out  SRC_AW  source word address
//  src_q_i         in   32      source read data (1-cycle latency)
//  dst_req_o       out  1       write request
//  dst_gnt_i       in   1       write grant; a beat transfers when req&gnt
//  dst_addr_o      out  32      write byte address
//  dst_we_o        out  1       always 1 while req
//  dst_be_o        out  4       always 4'hF while req
//  dst_wdata_o     out  32      write data
//  busy_o          out  1       load in progress
//  done_o          out  1       sticky: load succeeded
//  error_o         out  1       sticky: load failed
//  err_code_o      out  2       0 none, 1 bad magic, 2 bad length, 3 checksum mismatch
//  fetch_enable_o  out  1       core fetch enable; high only in DONE
// BEHAVIOUR
//  Reset: all outputs 0 except src_csn_o=1; src_a_o=0, dst_* =0; state IDLE.
//  Image: word0=MAGIC, word1=N, words 2..N+1 payload, word N+2 = XOR of all payload words.
//  Payload word i is written to DST_BASE+4*i.
//  FSM: IDLE -start_i-> RD_MAGIC (csn=0, a=0) -> CHK_MAGIC (compare Q; mismatch -> ERR code 1)
//   -> RD_LEN (a=1) -> CHK_LEN (N>MAX_WORDS or N+3>2**SRC_AW -> ERR code 2; N==0 -> RD_SUM)
//   -> RD_DATA (a=2+i) -> CAP (latch Q into wdata, XOR accumulate) -> WR (req=1 until gnt)
//   -> on gnt: i==N-1 ? RD_SUM : RD_DATA. RD_SUM (a=N+2) -> CHK_SUM (Q!=acc -> ERR code 3)
//   -> DONE. ERR and DONE hold until start_i or RST.
//  Source: src_csn_o low exactly one cycle per read (the RD_* states). Q is sampled in the following cycle only.
//  Dest handshake: once req rises, addr/wdata/we/be are stable and req stays high until gnt is sampled.
//   gnt without req is ignored. gnt in the same cycle as req rising completes the beat.
//  Throughput: 3 cycles/word with gnt tied high; total = 2N+... fixed cost is fine, only ordering is normative.
//  busy_o=1 in every state except IDLE/DONE/ERR. done_o/error_o/err_code_o are registered.
//   They are cleared on the cycle start_i is accepted.
//  start_i while busy: ignored. start_i in DONE/ERR: restart from RD_MAGIC, fetch_enable_o drops.
//  Checksum failure: payload writes already issued are not undone; fetch_enable_o stays 0.
//  Arithmetic: word index is a counter of width $clog2(MAX_WORDS+1). Dest address = DST_BASE + {i,2'b00} in 32 bits.
//   Source address N+2 is computed in SRC_AW+1 bits; the overflow check is made before any read beyond word 1.
//  RST mid-load: back to IDLE next edge and dst_req_o drops without gnt (the only allowed req withdrawal).
//   The RAM side must tolerate this.
// STRUCTURE
//  Package boot_loader_pkg: state enum, err_code_t enum {ERR_NONE,ERR_MAGIC,ERR_LEN,ERR_SUM}, default MAGIC.
//  Single module, no sub-module: one FSM, index counter, XOR accumulator, wdata/addr registers.
// TESTING
//  1 Image MAGIC,N=3,{11,22,33},sum=0x00 (11^22^33); gnt=1 -> writes 0x0/0x4/0x8 = 11,22,33;
//    done_o=1, fetch_enable_o=1, err_code_o=0.
//  2 Word0=0xDEADBEEF -> error_o=1, err_code_o=1 on CHK_MAGIC+1; no dst_req_o ever asserted.
//  3 N=MAX_WORDS+1 -> err_code_o=2. N=0 with word2=0 -> done_o=1, zero writes.
//  4 Random gnt stalls 0-5 cycles, N=16 -> addr/wdata stable during every stall; 16 beats, in order.
//  5 Bad checksum word (acc^1) -> all N writes seen, err_code_o=3, fetch_enable_o=0.
//    A subsequent start_i with a fixed image -> done_o=1.
//  6 RST asserted during WR with gnt=0 -> next cycle dst_req_o=0, busy_o=0, src_csn_o=1.
//    start_i during busy is ignored (no restart).

Source files
------------

// File: rtl/boot_image_loader_pkg.sv
// Shared types and defaults for the boot image loader.
package boot_image_loader_pkg;

    // Value a valid image must carry in source word 0.
    localparam logic [31:0] DefaultMagic = 32'hB007_C0DE;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_MAGIC = 2'd1,
        ERR_LEN   = 2'd2,
        ERR_SUM   = 2'd3
    } err_code_t;

    typedef enum logic [3:0] {
        StIdle,
        StRdMagic,
        StChkMagic,
        StRdLen,
        StChkLen,
        StRdData,
        StCap,
        StWr,
        StRdSum,
        StChkSum,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/boot_image_loader_if.sv
// Source ROM read port plus instruction-RAM write port, seen from the loader.
interface boot_image_loader_if #(
    parameter int unsigned SRC_AW = 10
) ();

    // ROM side: active-low strobe, word address, data one cycle after the strobe.
    logic              src_csn_o;
    logic [SRC_AW-1:0] src_a_o;
    logic [31:0]       src_q_i;

    // RAM side: req/gnt write port, beat transfers on req & gnt.
    logic              dst_req_o;
    logic              dst_gnt_i;
    logic [31:0]       dst_addr_o;
    logic              dst_we_o;
    logic [3:0]        dst_be_o;
    logic [31:0]       dst_wdata_o;

    modport master (
        output src_csn_o, src_a_o, dst_req_o, dst_addr_o, dst_we_o, dst_be_o, dst_wdata_o,
        input  src_q_i, dst_gnt_i
    );

    modport slave (
        input  src_csn_o, src_a_o, dst_req_o, dst_addr_o, dst_we_o, dst_be_o, dst_wdata_o,
        output src_q_i, dst_gnt_i
    );

endinterface

// File: rtl/boot_image_loader.sv
// Boot sequencer: reads MAGIC, length, payload and XOR checksum from the boot ROM,
// copies the payload into instruction RAM and releases the core on success.
module boot_image_loader
    import boot_image_loader_pkg::*;
#(
    parameter int unsigned SRC_AW    = 10,
    parameter logic [31:0] DST_BASE  = 32'h0000_0000,
    parameter logic [31:0] MAGIC     = DefaultMagic,
    parameter int unsigned MAX_WORDS = 512
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_i,
    boot_image_loader_if.master bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output err_code_t           err_code_o,
    output logic                fetch_enable_o
);

    localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);

    state_e            state_q;
    logic              csn_q;
    logic [SRC_AW-1:0] a_q;
    logic              req_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   len_q;
    logic [31:0]       acc_q;
    logic              done_q;
    logic              error_q;
    err_code_t         code_q;
    logic              fetch_q;

    logic [32:0]       len_plus3;
    logic              len_bad;
    logic [SRC_AW:0]   next_data_a;
    logic [SRC_AW:0]   sum_a;
    logic [31:0]       beat_addr;

    // Length check and address arithmetic, widened so nothing wraps before comparing.
    always_comb begin
        len_plus3   = {1'b0, bus.src_q_i} + 33'd3;
        len_bad     = (bus.src_q_i > 32'(MAX_WORDS)) || (len_plus3 > (33'd1 << SRC_AW));
        next_data_a = (SRC_AW+1)'(idx_q) + (SRC_AW+1)'(3);
        sum_a       = (SRC_AW+1)'(len_q) + (SRC_AW+1)'(2);
        beat_addr   = DST_BASE + 32'({idx_q, 2'b00});
    end

    // Load sequencer with all outputs registered; csn is pulsed low for one cycle per read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            csn_q   <= 1'b1;
            a_q     <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
            fetch_q <= 1'b0;
        end else begin
            csn_q <= 1'b1;
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (start_i) begin
                        state_q <= StRdMagic;
                        csn_q   <= 1'b0;
                        a_q     <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        code_q  <= ERR_NONE;
                        fetch_q <= 1'b0;
                    end
                end
                StRdMagic: state_q <= StChkMagic;
                StChkMagic: begin
                    if (bus.src_q_i != MAGIC) begin
                        state_q <= StErr;
                        error_q <= 1'b1;
                        code_q  <= ERR_MAGIC;
                    end else begin
                        state_q <= StRdLen;
                        csn_q   <= 1'b0;
                        a_q     <= SRC_AW'(1);
                    end
                end
                StRdLen: state_q <= StChkLen;
                StChkLen: begin
                    if (len_bad) begin
                        state_q <= StErr;
                        error_q <= 1'b1;
                        code_q  <= ERR_LEN;
                    end else begin
                        // Word 2 is either the first payload word or, for N == 0, the checksum.
                        len_q   <= bus.src_q_i[IdxW-1:0];
                        idx_q   <= '0;
                        acc_q   <= '0;
                        csn_q   <= 1'b0;
                        a_q     <= SRC_AW'(2);
                        state_q <= (bus.src_q_i == 32'd0) ? StRdSum : StRdData;
                    end
                end
                StRdData: state_q <= StCap;
                StCap: begin
                    wdata_q <= bus.src_q_i;
                    acc_q   <= acc_q ^ bus.src_q_i;
                    addr_q  <= beat_addr;
                    req_q   <= 1'b1;
                    state_q <= StWr;
                end
                StWr: begin
                    if (bus.dst_gnt_i) begin
                        req_q <= 1'b0;
                        csn_q <= 1'b0;
                        if (idx_q == len_q - IdxW'(1)) begin
                            a_q     <= sum_a[SRC_AW-1:0];
                            state_q <= StRdSum;
                        end else begin
                            idx_q   <= idx_q + IdxW'(1);
                            a_q     <= next_data_a[SRC_AW-1:0];
                            state_q <= StRdData;
                        end
                    end
                end
                StRdSum: state_q <= StChkSum;
                StChkSum: begin
                    if (bus.src_q_i != acc_q) begin
                        state_q <= StErr;
                        error_q <= 1'b1;
                        code_q  <= ERR_SUM;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        fetch_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.src_csn_o   = csn_q;
    assign bus.src_a_o     = a_q;
    assign bus.dst_req_o   = req_q;
    assign bus.dst_addr_o  = addr_q;
    assign bus.dst_wdata_o = wdata_q;
    assign bus.dst_we_o    = req_q;
    assign bus.dst_be_o    = {4{req_q}};

    assign busy_o         = !(state_q inside {StIdle, StDone, StErr});
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_code_o     = code_q;
    assign fetch_enable_o = fetch_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Self-checking bench: ROM/RAM models, an image-level reference model and a per-cycle monitor.
module tb_boot_image_loader;
    import boot_image_loader_pkg::*;

    localparam int unsigned SrcAw    = 10;
    localparam int unsigned MaxWords = 512;
    localparam logic [31:0] DstBase  = 32'h0000_0000;
    localparam logic [31:0] Magic    = 32'hB007_C0DE;
    localparam int          RomWords = 1 << SrcAw;

    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      start = 1'b0;
    logic      busy, done, error, fetch;
    err_code_t code;

    boot_image_loader_if #(.SRC_AW(SrcAw)) bus ();

    boot_image_loader #(
        .SRC_AW   (SrcAw),
        .DST_BASE (DstBase),
        .MAGIC    (Magic),
        .MAX_WORDS(MaxWords)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start_i       (start),
        .bus           (bus),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .err_code_o    (code),
        .fetch_enable_o(fetch)
    );

    always #5 CLK = ~CLK;

    logic [31:0] rom [RomWords];

    // ROM: data appears one cycle after the strobe edge and holds while csn is high.
    always @(posedge CLK) begin
        if (!bus.src_csn_o) bus.src_q_i <= rom[bus.src_a_o];
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor state.
    bit          mon_en = 1'b0;
    int          gnt_mode = 1;        // 0 low, 1 high, 2 random stalls
    int          stall_left = 0;
    int          beat_total = 0;
    int          read_total = 0;
    int          req_cycles = 0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_rst = 1'b1, prev_csn = 1'b1;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] log_addr [1024];
    logic [31:0] log_data [1024];

    // Every cycle: handshake stability, strobe width, beat ordering; also drives gnt.
    always @(negedge CLK) begin
        logic [31:0] ea, ed;
        if (mon_en) begin
            if (prev_req && !prev_gnt && !prev_rst) begin
                check("req_hold", bus.dst_req_o, 1);
                check("addr_hold", bus.dst_addr_o, prev_addr);
                check("wdata_hold", bus.dst_wdata_o, prev_wdata);
            end
            if (bus.dst_req_o) begin
                req_cycles++;
                check("we", bus.dst_we_o, 1);
                check("be", bus.dst_be_o, 4'hF);
            end
            if (!prev_csn && !prev_rst) check("csn_one_cycle", bus.src_csn_o, 1);
            if (!bus.src_csn_o) read_total++;
        end
        case (gnt_mode)
            0: bus.dst_gnt_i = 1'b0;
            1: bus.dst_gnt_i = 1'b1;
            default: begin
                if (bus.dst_req_o) begin
                    if (stall_left == 0) begin
                        bus.dst_gnt_i = 1'b1;
                        stall_left = $urandom_range(0, 5);
                    end else begin
                        bus.dst_gnt_i = 1'b0;
                        stall_left--;
                    end
                end else begin
                    bus.dst_gnt_i = 1'($urandom_range(0, 1));
                end
            end
        endcase
        if (mon_en && bus.dst_req_o && bus.dst_gnt_i && !RST) begin
            if (exp_addr_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_beat: got addr %0h data %0h, expected no write",
                         bus.dst_addr_o, bus.dst_wdata_o);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("beat_addr", bus.dst_addr_o, ea);
                check("beat_data", bus.dst_wdata_o, ed);
            end
            log_addr[beat_total % 1024] = bus.dst_addr_o;
            log_data[beat_total % 1024] = bus.dst_wdata_o;
            beat_total++;
        end
        prev_req   = bus.dst_req_o;
        prev_gnt   = bus.dst_gnt_i;
        prev_rst   = RST;
        prev_csn   = bus.src_csn_o;
        prev_addr  = bus.dst_addr_o;
        prev_wdata = bus.dst_wdata_o;
    end

    // Reference: outcome, payload writes and read count follow from the image contents alone.
    function automatic void model(output int mcode, output int nw, output int nrd);
        longint unsigned n;
        logic [31:0]     x;
        mcode = 0;
        nw    = 0;
        nrd   = 0;
        if (rom[0] != Magic) begin
            mcode = 1;
            nrd   = 1;
        end else begin
            n = longint'(rom[1]);
            if (n > MaxWords || n + 3 > RomWords) begin
                mcode = 2;
                nrd   = 2;
            end else begin
                x = '0;
                for (int i = 0; i < int'(n); i++) x ^= rom[2 + i];
                mcode = (rom[int'(n) + 2] == x) ? 0 : 3;
                nw    = int'(n);
                nrd   = int'(n) + 3;
            end
        end
    endfunction

    // kind: 0 good, 1 bad magic, 2 bad checksum, 3 bad length
    task automatic build(input int n, input int kind);
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < n; i++) begin
            rom[2 + i] = $urandom;
            x ^= rom[2 + i];
        end
        rom[0]     = Magic;
        rom[1]     = n;
        rom[n + 2] = (kind == 2) ? (x ^ 32'd1) : x;
        if (kind == 1) rom[0] = Magic ^ (32'd1 << $urandom_range(0, 31));
        if (kind == 3) rom[1] = $urandom_range(MaxWords + 1, 100000);
    endtask

    task automatic pulse_start();
        @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic run_load(input bit poke, output int mcode);
        int nw, nrd, rb, bb, cyc, budget;
        model(mcode, nw, nrd);
        for (int i = 0; i < nw; i++) begin
            exp_addr_q.push_back(DstBase + 32'(4 * i));
            exp_data_q.push_back(rom[2 + i]);
        end
        rb = read_total;
        bb = beat_total;
        budget = 20 * nw + 200;
        pulse_start();
        check("start_busy", busy, 1);
        check("start_clr_done", done, 0);
        check("start_clr_err", error, 0);
        check("start_clr_fetch", fetch, 0);
        cyc = 0;
        while (busy && cyc < budget) begin
            @(posedge CLK);
            #1;
            cyc++;
            start = (poke && cyc == 10) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check("load_timeout", busy, 0);
        check("done", done, (mcode == 0));
        check("error", error, (mcode != 0));
        check("err_code", code, mcode);
        check("fetch_enable", fetch, (mcode == 0));
        check("beat_count", beat_total - bb, nw);
        check("read_count", read_total - rb, nrd);
        check("beats_left", exp_addr_q.size(), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int mc, b0, rq0, cyc;
        for (int i = 0; i < RomWords; i++) rom[i] = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_csn", bus.src_csn_o, 1);
        check("rst_a", bus.src_a_o, 0);
        check("rst_req", bus.dst_req_o, 0);
        check("rst_addr", bus.dst_addr_o, 0);
        check("rst_wdata", bus.dst_wdata_o, 0);
        check("rst_we", bus.dst_we_o, 0);
        check("rst_be", bus.dst_be_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_code", code, 0);
        check("rst_fetch", fetch, 0);
        RST    = 1'b0;
        mon_en = 1'b1;

        // 1: three-word image, gnt tied high
        gnt_mode = 1;
        rom[0] = Magic; rom[1] = 3;
        rom[2] = 32'h11; rom[3] = 32'h22; rom[4] = 32'h33; rom[5] = 32'h0;
        b0 = beat_total;
        run_load(1'b0, mc);
        check("t1_model_code", mc, 0);
        check("t1_w0_addr", log_addr[b0], 32'h0);
        check("t1_w0_data", log_data[b0], 32'h11);
        check("t1_w1_addr", log_addr[b0 + 1], 32'h4);
        check("t1_w2_addr", log_addr[b0 + 2], 32'h8);
        check("t1_w2_data", log_data[b0 + 2], 32'h33);
        check("t1_done", done, 1);
        check("t1_fetch", fetch, 1);

        // 2: bad magic, error exactly one cycle after the magic check, no writes
        rom[0] = 32'hDEAD_BEEF;
        b0  = beat_total;
        rq0 = req_cycles;
        pulse_start();
        @(posedge CLK);
        #1 check("t2_err_early", error, 0);
        @(posedge CLK);
        #1 check("t2_err", error, 1);
        check("t2_code", code, 1);
        check("t2_busy", busy, 0);
        repeat (5) @(posedge CLK);
        #1 check("t2_no_beats", beat_total - b0, 0);
        check("t2_no_req", req_cycles - rq0, 0);

        // 3: length one over the limit, then an empty image
        rom[0] = Magic; rom[1] = MaxWords + 1;
        run_load(1'b0, mc);
        check("t3_model_code", mc, 2);
        rom[1] = 0; rom[2] = 0;
        run_load(1'b0, mc);
        check("t3_empty_code", mc, 0);
        check("t3_empty_done", done, 1);

        // 4: random grant stalls on a 16-word image
        gnt_mode = 2;
        build(16, 0);
        run_load(1'b0, mc);

        // 5: bad checksum, then the repaired image
        build(8, 2);
        run_load(1'b0, mc);
        check("t5_model_code", mc, 3);
        check("t5_fetch", fetch, 0);
        rom[10] = rom[10] ^ 32'd1;
        run_load(1'b0, mc);
        check("t5_fixed_done", done, 1);

        // start_i while busy must not restart the load
        gnt_mode = 1;
        build(16, 0);
        run_load(1'b1, mc);

        // Random images under random stalls
        gnt_mode = 2;
        for (int k = 0; k < 8; k++) begin
            build($urandom_range(0, 40), $urandom_range(0, 3));
            run_load(1'b0, mc);
        end

        // 6: reset while a write waits for grant
        gnt_mode = 0;
        build(4, 0);
        pulse_start();
        cyc = 0;
        while (!bus.dst_req_o && cyc < 50) begin
            @(posedge CLK);
            #1 cyc++;
        end
        check("t6_req_reached", bus.dst_req_o, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1 check("t6_req_drop", bus.dst_req_o, 0);
        check("t6_busy", busy, 0);
        check("t6_csn", bus.src_csn_o, 1);
        RST = 1'b0;
        gnt_mode = 1;
        run_load(1'b0, mc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
